muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk and rst_n.
REQ-002 The clk port SHALL be an input, 1 bit wide, and SHALL be the only clock; all state updates on its rising edge.
REQ-003 The rst_n port SHALL be an input, 1 bit wide, asynchronous and active-low.
REQ-004 The start port SHALL be an input, 1 bit wide; it requests an M-extension operation held in ID/EX.
REQ-005 The funct3 port SHALL be an input, 3 bits wide, with this encoding:
- 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
- 100 DIV, 101 DIVU, 110 REM, 111 REMU
REQ-006 The op_a port SHALL be an input, 32 bits wide: the rs1 operand after the EX-stage forwarding mux.
REQ-007 The op_b port SHALL be an input, 32 bits wide: the rs2 operand after the EX-stage forwarding mux.
REQ-008 The flush port SHALL be an input, 1 bit wide: a synchronous cancel from branch/exception logic.
REQ-009 The stall port SHALL be an output, 1 bit wide; it freezes PC, IF/ID and ID/EX and holds forwarding inputs stable.
REQ-010 The busy port SHALL be an output, 1 bit wide; it is high while state is MUL or DIV.
REQ-011 The done port SHALL be an output, 1 bit wide; it is high for exactly one cycle when result is valid.
REQ-012 The result port SHALL be an output, 32 bits wide: the registered operation result, forwarded to EX/MEM.

Function
REQ-013 The block SHALL have four states: IDLE, MUL, DIV, DONE.
REQ-014 In IDLE, when start=1 and flush=0, the block SHALL capture op_a, op_b and funct3 at the clock edge.
REQ-015 The IDLE transition SHALL depend on the operation:
- funct3[2]=0: go to MUL
- funct3[2]=1 with op_b=0, or signed overflow: go directly to DONE
- otherwise: go to DIV
REQ-016 MUL SHALL form a 64-bit product with operand signedness as follows, register the selected word, and go to DONE next cycle:
- MULH: both signed
- MULHSU: a signed, b unsigned
- MULHU and MUL: unsigned
REQ-017 MUL SHALL select product[31:0] for MUL and product[63:32] for all other multiply ops.
REQ-018 DIV SHALL run a radix-2 restoring divider on magnitudes for exactly 32 cycles, counted by a 5-bit counter, then go to DONE.
REQ-019 DIV SHALL apply sign correction at the end:
- quotient negated if operand signs differ (DIV)
- remainder takes the dividend sign (REM)
REQ-020 Divide by zero SHALL produce:
- DIV/DIVU: 0xFFFFFFFF
- REM/REMU: op_a
REQ-021 Signed overflow (op_a=0x80000000, op_b=0xFFFFFFFF, DIV/REM) SHALL produce:
- DIV: 0x80000000
- REM: 0x00000000
REQ-022 In DONE, done SHALL be 1, stall SHALL be 0, and the next state SHALL be IDLE unconditionally.
REQ-023 start SHALL be ignored in DONE.
REQ-024 stall SHALL equal (state==IDLE && start && !flush) || state==MUL || state==DIV.
REQ-025 Latency from the start cycle T SHALL be:
- MUL ops: done at T+2
- divide special cases: done at T+1
- normal divides: done at T+34
REQ-026 result SHALL update only on entry to DONE and SHALL hold its value otherwise.
REQ-027 flush=1 in any state SHALL force IDLE next cycle, and SHALL suppress done and any result update.
REQ-028 flush SHALL take priority over start.
REQ-029 start with flush in the same IDLE cycle SHALL be discarded.
REQ-030 op_a and op_b SHALL be ignored after capture; changes mid-operation SHALL NOT affect result.

Reset
REQ-031 When rst_n=0, the block SHALL force asynchronously: state=IDLE, counter=0, result=0, and done, busy and stall all 0.
REQ-032 Reset asserted mid-DIV SHALL abort the operation with no done pulse.
REQ-033 After rst_n deasserts, the first start SHALL be accepted on the next clock edge.

Verification
REQ-034 MUL 0x00010000 x 0x00010000 -> result 0x00000000, done at T+2; MULHU same operands -> 0x00000001.
REQ-035 MULH 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000000; MULHU -> 0xFFFFFFFE; MULHSU -> 0xFFFFFFFF.
REQ-036 DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD, done at T+34, stall high T..T+33; REM same operands -> 0xFFFFFFFF.
REQ-037 DIVU 5/0 -> 0xFFFFFFFF at T+1; REM 0x80000000 / 0xFFFFFFFF -> 0x00000000 at T+1.
REQ-038 DIV started, flush at T+10 -> IDLE at T+11, no done, result unchanged; new start at T+11 accepted.
REQ-039 rst_n low at T+5 of a DIV -> all outputs 0 immediately; back-to-back MUL issued in the cycle after DONE -> done at +2 again.

Source files
------------

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide: MUL done 2 cycles after start, divide specials 1, normal divides 34.
// Backpressure: stall freezes the front end from the accepting cycle until DONE; flush cancels.
module muldiv_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        flush,
    output logic        stall,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] result_q, result_d;
    logic [2:0]  f3_q, f3_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        fix_q, fix_d;
    logic        neg_quo_q, neg_quo_d;
    logic        neg_rem_q, neg_rem_d;

    logic        sgn_div;
    logic        div_zero;
    logic        div_ovf;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] special_res;
    logic signed [32:0] mul_a;
    logic signed [32:0] mul_b;
    logic [63:0] prod;
    logic [32:0] shifted;
    logic [33:0] diff;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    always_comb begin
        sgn_div     = ~funct3[0];
        div_zero    = (op_b == 32'd0);
        div_ovf     = sgn_div && (op_a == 32'h8000_0000) && (op_b == 32'hFFFF_FFFF);
        mag_a       = (sgn_div && op_a[31]) ? -op_a : op_a;
        mag_b       = (sgn_div && op_b[31]) ? -op_b : op_b;
        if (funct3[1])
            special_res = div_zero ? op_a : 32'd0;
        else
            special_res = div_zero ? 32'hFFFF_FFFF : 32'h8000_0000;

        // Only MULH and MULHSU treat rs1 as signed; only MULH treats rs2 as signed.
        mul_a = {((f3_q == 3'b001) || (f3_q == 3'b010)) & a_q[31], a_q};
        mul_b = {(f3_q == 3'b001) & b_q[31], b_q};
        prod  = mul_a * mul_b;

        // a_q doubles as the dividend/quotient shift register while dividing.
        shifted = {rem_q, a_q[31]};
        diff    = {1'b0, shifted} - {2'b00, b_q};
        quo_fix = neg_quo_q ? -a_q : a_q;
        rem_fix = neg_rem_q ? -rem_q : rem_q;
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        rem_d     = rem_q;
        result_d  = result_q;
        f3_d      = f3_q;
        cnt_d     = cnt_q;
        fix_d     = fix_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;

        case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    f3_d      = funct3;
                    cnt_d     = 5'd0;
                    fix_d     = 1'b0;
                    rem_d     = 32'd0;
                    neg_quo_d = sgn_div && (op_a[31] ^ op_b[31]);
                    neg_rem_d = sgn_div && op_a[31];
                    if (!funct3[2]) begin
                        a_d     = op_a;
                        b_d     = op_b;
                        state_d = S_MUL;
                    end else if (div_zero || div_ovf) begin
                        result_d = special_res;
                        state_d  = S_DONE;
                    end else begin
                        a_d     = mag_a;
                        b_d     = mag_b;
                        state_d = S_DIV;
                    end
                end
            end
            S_MUL: begin
                result_d = (f3_q == 3'b000) ? prod[31:0] : prod[63:32];
                state_d  = S_DONE;
            end
            S_DIV: begin
                // 32 iteration cycles, then one cycle to apply sign correction.
                if (fix_q) begin
                    result_d = f3_q[1] ? rem_fix : quo_fix;
                    fix_d    = 1'b0;
                    state_d  = S_DONE;
                end else begin
                    if (diff[33]) begin
                        rem_d = shifted[31:0];
                        a_d   = {a_q[30:0], 1'b0};
                    end else begin
                        rem_d = diff[31:0];
                        a_d   = {a_q[30:0], 1'b1};
                    end
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31)
                        fix_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (flush) begin
            state_d  = S_IDLE;
            result_d = result_q;
            cnt_d    = 5'd0;
            fix_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            a_q       <= 32'd0;
            b_q       <= 32'd0;
            rem_q     <= 32'd0;
            result_q  <= 32'd0;
            f3_q      <= 3'd0;
            cnt_q     <= 5'd0;
            fix_q     <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            rem_q     <= rem_d;
            result_q  <= result_d;
            f3_q      <= f3_d;
            cnt_q     <= cnt_d;
            fix_q     <= fix_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    always_comb begin
        busy   = (state_q == S_MUL) || (state_q == S_DIV);
        done   = (state_q == S_DONE);
        // Gated by rst_n so a start held during reset cannot raise stall.
        stall  = rst_n && (((state_q == S_IDLE) && start && !flush) || busy);
        result = result_q;
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: arithmetic reference model with a per-cycle compare process.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] op_a = 32'd0;
    logic [31:0] op_b = 32'd0;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int total = 0;
    int bad = 0;

    muldiv_unit dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .flush  (flush),
        .stall  (stall),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub, p;
        longint unsigned up;
        logic [63:0] pv;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        case (f3)
            3'd0: begin up = ua * ub; pv = up; return pv[31:0]; end
            3'd1: begin p = sa * sb; pv = p; return pv[63:32]; end
            3'd2: begin p = sa * ub; pv = p; return pv[63:32]; end
            3'd3: begin up = ua * ub; pv = up; return pv[63:32]; end
            default: begin
                if (b == 0) return f3[1] ? a : 32'hFFFF_FFFF;
                if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    return f3[1] ? 32'd0 : 32'h8000_0000;
                if (!f3[0]) begin
                    p = f3[1] ? (sa % sb) : (sa / sb);
                end else begin
                    p = f3[1] ? (ua % ub) : (ua / ub);
                end
                pv = p;
                return pv[31:0];
            end
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (!f3[2]) return 2;
        if (b == 0) return 1;
        if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    // Compare process: tracks one outstanding op as (accept cycle, done cycle, result).
    initial begin : monitor
        bit act;
        bit in_op;
        bit is_done;
        bit idle;
        int cyc;
        int done_cyc;
        logic [31:0] pend;
        logic [31:0] cur;
        act = 0; cyc = 0; done_cyc = 0; pend = 0; cur = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                act = 0;
                cur = 0;
                chk("rst_stall", {31'd0, stall}, 32'd0);
                chk("rst_busy", {31'd0, busy}, 32'd0);
                chk("rst_done", {31'd0, done}, 32'd0);
                chk("rst_result", result, 32'd0);
            end else begin
                in_op   = act && (cyc < done_cyc);
                is_done = act && (cyc == done_cyc);
                idle    = !act;
                if (is_done) cur = pend;
                chk("stall", {31'd0, stall}, {31'd0, in_op || (idle && start && !flush)});
                chk("busy", {31'd0, busy}, {31'd0, in_op});
                chk("done", {31'd0, done}, {31'd0, is_done});
                chk("result", result, cur);
                if (is_done || (in_op && flush)) begin
                    act = 0;
                end else if (idle && start && !flush) begin
                    act      = 1;
                    done_cyc = cyc + ref_lat(funct3, op_a, op_b);
                    pend     = ref_res(funct3, op_a, op_b);
                end
            end
        end
    end

    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input bit check, input logic [31:0] er, input int el, input bit now);
        int lat;
        bit got;
        if (!now) begin
            @(posedge clk); #1;
        end
        start = 1; funct3 = f3; op_a = a; op_b = b; flush = 0;
        @(posedge clk); #1;
        start = 0; funct3 = 3'($urandom); op_a = $urandom; op_b = $urandom;
        lat = 1;
        got = 0;
        while (!got && lat < 60) begin
            @(negedge clk);
            if (done) got = 1;
            else begin
                @(posedge clk); #1;
                lat++;
            end
        end
        if (!got) chk("timeout", 32'd0, 32'd1);
        else if (check) begin
            chk("dir_result", result, er);
            chk("dir_latency", lat, el);
        end
    endtask

    task automatic run_flush(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input int k);
        @(posedge clk); #1;
        start = 1; funct3 = f3; op_a = a; op_b = b; flush = 0;
        @(posedge clk); #1;
        start = 0; op_a = $urandom; op_b = $urandom;
        repeat (k - 1) begin
            @(posedge clk); #1;
        end
        flush = 1;
        @(posedge clk); #1;
        flush = 0;
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        int sel;
        int lat;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;

        chk("model_mul", ref_res(3'd0, 32'h0001_0000, 32'h0001_0000), 32'h0000_0000);
        chk("model_mulhu", ref_res(3'd3, 32'h0001_0000, 32'h0001_0000), 32'h0000_0001);
        chk("model_mulh", ref_res(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'h0000_0000);
        chk("model_mulhsu", ref_res(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFF);
        chk("model_div", ref_res(3'd4, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
        chk("model_rem", ref_res(3'd6, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
        chk("model_lat_div", ref_lat(3'd4, 32'hFFFF_FFF9, 32'd2), 34);

        run_op(3'd0, 32'h0001_0000, 32'h0001_0000, 1, 32'h0000_0000, 2, 0);
        run_op(3'd3, 32'h0001_0000, 32'h0001_0000, 1, 32'h0000_0001, 2, 0);
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'h0000_0000, 2, 0);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFE, 2, 0);
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 2, 0);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 1, 32'hFFFF_FFFD, 34, 0);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 1, 32'hFFFF_FFFF, 34, 0);
        run_op(3'd5, 32'd5, 32'd0, 1, 32'hFFFF_FFFF, 1, 0);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h0000_0000, 1, 0);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, 1, 0);
        run_op(3'd7, 32'd9, 32'd0, 1, 32'd9, 1, 0);
        run_op(3'd5, 32'd100, 32'd7, 1, 32'd14, 34, 0);

        // Flush a divide at T+10, then start a new one at T+11.
        run_flush(3'd4, 32'hFFFF_FFF9, 32'd2, 10);
        chk("flush_hold", result, 32'd14);
        run_op(3'd5, 32'd1000, 32'd7, 1, 32'd142, 34, 1);

        // Start together with flush in IDLE must be dropped.
        @(posedge clk); #1;
        start = 1; flush = 1; funct3 = 3'd0; op_a = 32'd3; op_b = 32'd5;
        @(posedge clk); #1;
        start = 0; flush = 0;
        @(negedge clk);
        chk("discard_busy", {31'd0, busy}, 32'd0);
        chk("discard_result", result, 32'd142);

        // Reset at T+5 of a divide.
        @(posedge clk); #1;
        start = 1; funct3 = 3'd4; op_a = 32'd100; op_b = 32'd3;
        @(posedge clk); #1;
        start = 0;
        repeat (4) @(posedge clk);
        #1 rst_n = 0;
        #1;
        chk("arst_stall", {31'd0, stall}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_done", {31'd0, done}, 32'd0);
        chk("arst_result", result, 32'd0);
        @(posedge clk);
        @(negedge clk);
        #1 rst_n = 1;
        run_op(3'd0, 32'd7, 32'd6, 1, 32'd42, 2, 0);
        run_op(3'd0, 32'd3, 32'd5, 1, 32'd15, 2, 0);

        for (int i = 0; i < 40; i++) begin
            f3  = 3'($urandom);
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) b = 32'd0;
            else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (sel == 2) begin a = $urandom_range(0, 50); b = $urandom_range(1, 9); end
            else if (sel == 3) b = $urandom_range(1, 4) | ($urandom_range(0, 1) == 1 ? 32'hFFFF_FFF0 : 32'd0);
            lat = ref_lat(f3, a, b);
            if (lat > 1 && $urandom_range(0, 5) == 0)
                run_flush(f3, a, b, $urandom_range(1, lat - 1));
            else
                run_op(f3, a, b, 0, 32'd0, 0, 0);
        end

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
